// File: rtl/chip8_alu_pkg.sv
// Shared constants for the CHIP-8 8XYN sequencer: ALU op codes, nibble codes, FSM states.
package chip8_alu_pkg;

  localparam logic [2:0] ALU_PASS_Y = 3'd0;
  localparam logic [2:0] ALU_OR     = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_XOR    = 3'd3;
  localparam logic [2:0] ALU_ADD    = 3'd4;
  localparam logic [2:0] ALU_SUB    = 3'd5;
  localparam logic [2:0] ALU_SHR    = 3'd6;
  localparam logic [2:0] ALU_SHL    = 3'd7;

  localparam logic [3:0] N_LD   = 4'h0;
  localparam logic [3:0] N_OR   = 4'h1;
  localparam logic [3:0] N_AND  = 4'h2;
  localparam logic [3:0] N_XOR  = 4'h3;
  localparam logic [3:0] N_ADD  = 4'h4;
  localparam logic [3:0] N_SUB  = 4'h5;
  localparam logic [3:0] N_SHR  = 4'h6;
  localparam logic [3:0] N_SUBN = 4'h7;
  localparam logic [3:0] N_SHL  = 4'hE;

  localparam logic [3:0] VF_ADDR = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_X,
    S_RD_Y,
    S_EXEC,
    S_WB_X,
    S_WB_F
  } state_t;

endpackage

// File: rtl/chip8_alu_op_decode.sv
// Maps the 8XYN low nibble to ALU op, operand swap, flag-write and legality.
// CHIP8_VF_RESET_QUIRK_EN: OR/AND/XOR also write VF (value 0).
module chip8_alu_op_decode
  import chip8_alu_pkg::*;
(
  input  logic [3:0] op_n,
  output logic [2:0] alu_op,
  output logic       swap,
  output logic       flag_wr,
  output logic       legal
);

  always_comb begin
    alu_op  = ALU_PASS_Y;
    swap    = 1'b0;
    flag_wr = 1'b0;
    legal   = 1'b1;
    case (op_n)
      N_LD:   alu_op = ALU_PASS_Y;
`ifdef CHIP8_VF_RESET_QUIRK_EN
      N_OR:   begin alu_op = ALU_OR;  flag_wr = 1'b1; end
      N_AND:  begin alu_op = ALU_AND; flag_wr = 1'b1; end
      N_XOR:  begin alu_op = ALU_XOR; flag_wr = 1'b1; end
`else
      N_OR:   alu_op = ALU_OR;
      N_AND:  alu_op = ALU_AND;
      N_XOR:  alu_op = ALU_XOR;
`endif
      N_ADD:  begin alu_op = ALU_ADD; flag_wr = 1'b1; end
      N_SUB:  begin alu_op = ALU_SUB; flag_wr = 1'b1; end
      N_SHR:  begin alu_op = ALU_SHR; flag_wr = 1'b1; end
      N_SUBN: begin alu_op = ALU_SUB; flag_wr = 1'b1; swap = 1'b1; end
      N_SHL:  begin alu_op = ALU_SHL; flag_wr = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/chip8_alu_sequencer.sv
// Sequences one CHIP-8 8XYN instruction: read Vx, Vy over a shared RF port, run ALU, write Vx then VF.
// Optional CHIP8_VF_RESET_QUIRK_EN (see chip8_alu_op_decode) clears VF after OR/AND/XOR.
module chip8_alu_sequencer
  import chip8_alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        op_n,
  input  logic [REG_AW-1:0] x_idx,
  input  logic [REG_AW-1:0] y_idx,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [REG_AW-1:0] rf_addr,
  output logic              rf_re,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry
);

  state_t            state_q, state_d;
  logic [REG_AW-1:0] xi_q, xi_d, yi_q, yi_d;
  logic [2:0]        aop_q, aop_d;
  logic              swap_q, swap_d, flag_q, flag_d;
  logic [DATA_W-1:0] x_q, x_d, res_q, res_d;
  logic              c_q, c_d, ill_q, ill_d;

  logic [2:0] dec_op;
  logic       dec_swap, dec_flag, dec_legal;

  chip8_alu_op_decode u_dec (
    .op_n    (op_n),
    .alu_op  (dec_op),
    .swap    (dec_swap),
    .flag_wr (dec_flag),
    .legal   (dec_legal)
  );

  always_comb begin
    state_d  = state_q;
    xi_d     = xi_q;
    yi_d     = yi_q;
    aop_d    = aop_q;
    swap_d   = swap_q;
    flag_d   = flag_q;
    x_d      = x_q;
    res_d    = res_q;
    c_d      = c_q;
    ill_d    = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = ill_q;
    illegal  = ill_q;
    rf_addr  = '0;
    rf_re    = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = '0;
    alu_x    = '0;
    alu_y    = '0;
    alu_op   = '0;
    case (state_q)
      S_IDLE: begin
        // The illegal pulse cycle is a done cycle, so a start there is dropped.
        if (start && !ill_q) begin
          xi_d   = x_idx;
          yi_d   = y_idx;
          aop_d  = dec_op;
          swap_d = dec_swap;
          flag_d = dec_flag;
          if (dec_legal) state_d = S_RD_X;
          else           ill_d   = 1'b1;
        end
      end
      S_RD_X: begin
        rf_addr = xi_q;
        rf_re   = 1'b1;
        state_d = S_RD_Y;
      end
      S_RD_Y: begin
        x_d     = rf_rdata;
        rf_addr = yi_q;
        rf_re   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_x   = swap_q ? rf_rdata : x_q;
        alu_y   = swap_q ? x_q : rf_rdata;
        alu_op  = aop_q;
        res_d   = alu_out;
        // Logic ops (op[2]==0) force the flag to 0 for the VF-reset variant.
        c_d     = alu_carry & aop_q[2];
        state_d = S_WB_X;
      end
      S_WB_X: begin
        rf_addr  = xi_q;
        rf_we    = 1'b1;
        rf_wdata = res_q;
        done     = !flag_q;
        state_d  = flag_q ? S_WB_F : S_IDLE;
      end
      S_WB_F: begin
        rf_addr  = REG_AW'(VF_ADDR);
        rf_we    = 1'b1;
        rf_wdata = {{(DATA_W-1){1'b0}}, c_q};
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      xi_q    <= '0;
      yi_q    <= '0;
      aop_q   <= '0;
      swap_q  <= 1'b0;
      flag_q  <= 1'b0;
      x_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xi_q    <= xi_d;
      yi_q    <= yi_d;
      aop_q   <= aop_d;
      swap_q  <= swap_d;
      flag_q  <= flag_d;
      x_q     <= x_d;
      res_q   <= res_d;
      c_q     <= c_d;
      ill_q   <= ill_d;
    end
  end

endmodule
